// File: rtl/bilinear_seq_ctrl.sv
// bilinear_seq_ctrl: walks every output pixel in raster order and issues one
// bilinear interpolation command per pixel to the datapath. It keeps no more
// than MAX_OUTSTANDING commands in flight.
// Optional busy-cycle counter: define BSEQ_PERF_EN to build perf_cycles.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | after reset, waiting for a start edge
// SETUP_DIV | restoring divide, inv = 65536 / scale (16 cyc)
// SETUP_DIM | output size and range check (1 cyc)
// RUN       | issuing one command per output pixel
// DRAIN     | last command sent, waiting for results
// DONE      | frame finished or config rejected
module bilinear_seq_ctrl #(
  parameter int MAX_DIM         = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        start,
  input  logic [15:0] cfg_in_w,
  input  logic [15:0] cfg_in_h,
  input  logic [15:0] cfg_scale_q88,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] cmd_x0,
  output logic [15:0] cmd_y0,
  output logic [7:0]  cmd_fx,
  output logic [7:0]  cmd_fy,
  output logic [15:0] cmd_ox,
  output logic [15:0] cmd_oy,
  output logic        cmd_last,
  input  logic        res_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] perf_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP_DIV, S_SETUP_DIM, S_RUN, S_DRAIN, S_DONE
  } state_t;

  localparam logic [23:0] MAX_DIM_L = 24'(MAX_DIM);
  localparam logic [3:0]  MAX_OS    = 4'(MAX_OUTSTANDING);

  state_t      state;
  logic        start_q;
  logic [15:0] in_w, in_h, scale, inv, div_rem, out_w, out_h;
  logic [3:0]  div_cnt, outstanding;
  logic [23:0] acc_x, acc_y;

  logic        start_edge, xfer, res_dec, row_end, rem_ge, nxt_last, dim_bad;
  logic [3:0]  os_next;
  logic [16:0] rem_sh;
  logic [23:0] dim_w, dim_h;
  logic [15:0] nxt_ox, nxt_oy;
  logic [23:0] nxt_acc_x, nxt_acc_y, pt_x, pt_y;

  // Split a Q16.8 position into {integer, fraction}, pinned to the last source pixel.
  function automatic logic [23:0] clamp_pt(input logic [23:0] acc, input logic [15:0] dim);
    logic [15:0] lim;
    lim = dim - 16'd1;
    if (acc[23:8] >= lim) clamp_pt = {lim, 8'h00};
    else                  clamp_pt = acc;
  endfunction

  assign start_edge = start & ~start_q;
  assign xfer       = cmd_valid & cmd_ready;
  assign res_dec    = res_valid & (outstanding != 4'd0);
  assign os_next    = outstanding + {3'd0, xfer} - {3'd0, res_dec};
  assign rem_sh     = {div_rem, 1'b0};
  assign rem_ge     = rem_sh >= {1'b0, scale};
  assign dim_w      = 24'((32'(in_w) * 32'(scale)) >> 8);
  assign dim_h      = 24'((32'(in_h) * 32'(scale)) >> 8);
  assign dim_bad    = (dim_w == 24'd0) || (dim_w > MAX_DIM_L) ||
                      (dim_h == 24'd0) || (dim_h > MAX_DIM_L);
  assign row_end    = (cmd_ox == out_w - 16'd1);

  // Next raster position and accumulator values after the current command.
  always_comb begin
    nxt_ox    = cmd_ox + 16'd1;
    nxt_oy    = cmd_oy;
    nxt_acc_x = acc_x + {8'd0, inv};
    nxt_acc_y = acc_y;
    if (row_end) begin
      nxt_ox    = 16'd0;
      nxt_oy    = cmd_oy + 16'd1;
      nxt_acc_x = 24'd0;
      nxt_acc_y = acc_y + {8'd0, inv};
    end
  end

  assign pt_x     = clamp_pt(nxt_acc_x, in_w);
  assign pt_y     = clamp_pt(nxt_acc_y, in_h);
  assign nxt_last = (nxt_ox == out_w - 16'd1) && (nxt_oy == out_h - 16'd1);

  // Start level history for edge detection.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) start_q <= 1'b0;
    else            start_q <= start;
  end

  // Sequencer FSM with registered command and status outputs.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state       <= S_IDLE;
      in_w        <= '0;
      in_h        <= '0;
      scale       <= '0;
      inv         <= '0;
      div_rem     <= '0;
      div_cnt     <= '0;
      out_w       <= '0;
      out_h       <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      outstanding <= '0;
      cmd_valid   <= 1'b0;
      cmd_x0      <= '0;
      cmd_y0      <= '0;
      cmd_fx      <= '0;
      cmd_fy      <= '0;
      cmd_ox      <= '0;
      cmd_oy      <= '0;
      cmd_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      outstanding <= os_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            in_w     <= cfg_in_w;
            in_h     <= cfg_in_h;
            scale    <= cfg_scale_q88;
            done     <= 1'b0;
            err      <= 1'b0;
            acc_x    <= '0;
            acc_y    <= '0;
            cmd_ox   <= '0;
            cmd_oy   <= '0;
            cmd_last <= 1'b0;
            // div_rem starts at 1: the dividend's only set bit has already been brought down
            inv      <= '0;
            div_rem  <= 16'd1;
            div_cnt  <= 4'd15;
            if (cfg_scale_q88 < 16'd2 || cfg_in_w == 16'd0 || cfg_in_h == 16'd0) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_SETUP_DIV;
            end
          end
        end
        S_SETUP_DIV: begin
          div_rem <= rem_ge ? 16'(rem_sh - {1'b0, scale}) : rem_sh[15:0];
          inv     <= {inv[14:0], rem_ge};
          div_cnt <= div_cnt - 4'd1;
          if (div_cnt == 4'd0) state <= S_SETUP_DIM;
        end
        S_SETUP_DIM: begin
          out_w <= dim_w[15:0];
          out_h <= dim_h[15:0];
          if (dim_bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            cmd_valid <= 1'b1;
            cmd_x0    <= '0;
            cmd_fx    <= '0;
            cmd_y0    <= '0;
            cmd_fy    <= '0;
            cmd_last  <= (dim_w == 24'd1) && (dim_h == 24'd1);
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (cmd_last) begin
              cmd_valid <= 1'b0;
              state     <= S_DRAIN;
            end else begin
              acc_x     <= nxt_acc_x;
              acc_y     <= nxt_acc_y;
              cmd_ox    <= nxt_ox;
              cmd_oy    <= nxt_oy;
              cmd_x0    <= pt_x[23:8];
              cmd_fx    <= pt_x[7:0];
              cmd_y0    <= pt_y[23:8];
              cmd_fy    <= pt_y[7:0];
              cmd_last  <= nxt_last;
              cmd_valid <= (os_next < MAX_OS);
            end
          end else if (!cmd_valid) begin
            cmd_valid <= (os_next < MAX_OS);
          end
        end
        S_DRAIN: begin
          if (outstanding == 4'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BSEQ_PERF_EN
  // Busy-cycle counter, cleared by an accepted start, saturating at all-ones.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n)
      perf_cycles <= '0;
    else if (start_edge && (state == S_IDLE || state == S_DONE))
      perf_cycles <= '0;
    else if (busy && perf_cycles != 32'hFFFF_FFFF)
      perf_cycles <= perf_cycles + 32'd1;
  end
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_bilinear_seq_ctrl.sv
// Directed bench for bilinear_seq_ctrl: hand-computed frame geometry plus a
// per-command reference model of the clamped source coordinates.
`timescale 1ns/1ps
module tb_bilinear_seq_ctrl;
  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_in_w = '0, cfg_in_h = '0, cfg_scale_q88 = '0;
  logic        cmd_valid, cmd_ready = 1'b0, cmd_last;
  logic [15:0] cmd_x0, cmd_y0, cmd_ox, cmd_oy;
  logic [7:0]  cmd_fx, cmd_fy;
  logic        res_valid;
  logic        busy, done, err;
  logic [31:0] perf_cycles;

  bilinear_seq_ctrl dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start(start),
    .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_fx(cmd_fx), .cmd_fy(cmd_fy),
    .cmd_ox(cmd_ox), .cmd_oy(cmd_oy), .cmd_last(cmd_last),
    .res_valid(res_valid), .busy(busy), .done(done), .err(err),
    .perf_cycles(perf_cycles)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected {x0, fx} for output coordinate o: position o*inv in Q16.8, clamped to dim-1.
  function automatic logic [23:0] mdl_pt(input int o, input int inv, input int dim);
    int acc, ip;
    acc = (o * inv) & 32'h00FF_FFFF;
    ip  = acc >> 8;
    if (ip >= dim - 1) return {16'(dim - 1), 8'd0};
    return 24'(acc);
  endfunction

  // frame parameters written by the stimulus process, read by the monitor
  int gen = 0;
  int exp_w = 1, exp_h = 1, exp_inv = 0, exp_iw = 1, exp_ih = 1;
  logic res_auto = 1'b1, res_man = 1'b0;

  // monitor-owned state
  int mon_gen = 0;
  int n_xfer = 0, n_valid = 0, n_last = 0, n_busy = 0;
  int exp_ox = 0, exp_oy = 0;
  logic [23:0] row0 [0:63];
  logic [15:0] last_ox = '0, last_oy = '0;
  logic [2:0]  dly = '0;

  // Negedge monitor: scores each transfer and returns results two cycles later.
  initial begin
    res_valid = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (gen != mon_gen) begin
        mon_gen = gen;
        n_xfer = 0; n_valid = 0; n_last = 0; n_busy = 0;
        exp_ox = 0; exp_oy = 0;
      end
      if (busy) n_busy++;
      if (cmd_valid) n_valid++;
      if (cmd_valid && cmd_ready) begin
        check("cmd_pos", 64'({cmd_ox, cmd_oy}), 64'({16'(exp_ox), 16'(exp_oy)}));
        check("cmd_pt", 64'({cmd_x0, cmd_fx, cmd_y0, cmd_fy}),
              64'({mdl_pt(exp_ox, exp_inv, exp_iw), mdl_pt(exp_oy, exp_inv, exp_ih)}));
        check("cmd_last", 64'(cmd_last), 64'((exp_ox == exp_w - 1) && (exp_oy == exp_h - 1)));
        if (cmd_oy == 16'd0 && cmd_ox < 16'd64) row0[cmd_ox[5:0]] = {cmd_x0, cmd_fx};
        if (cmd_last) begin
          n_last++;
          last_ox = cmd_ox;
          last_oy = cmd_oy;
        end
        n_xfer++;
        exp_ox++;
        if (exp_ox == exp_w) begin
          exp_ox = 0;
          exp_oy++;
        end
      end
      dly = {dly[1:0], cmd_valid & cmd_ready};
      res_valid = res_auto ? dly[2] : res_man;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Present a config and a start edge; returns just after the edge that samples it.
  task automatic start_frame(input int iw, input int ih, input int sc,
                             input int ew, input int eh, input int einv);
    cfg_in_w = 16'(iw);
    cfg_in_h = 16'(ih);
    cfg_scale_q88 = 16'(sc);
    exp_iw = iw; exp_ih = ih; exp_w = ew; exp_h = eh; exp_inv = einv;
    gen++;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    logic [31:0] snap_pos;
    logic [47:0] snap_pt;

    // reset state
    tick(3);
    check("rst_status", 64'({cmd_valid, busy, done, err, cmd_last}), 64'd0);
    check("rst_cmd", 64'({cmd_x0, cmd_fx, cmd_y0, cmd_fy}), 64'd0);
    check("rst_perf", 64'(perf_cycles), 64'd0);
    rst_sys_n = 1'b1;
    tick(2);

    // 1: 64x64, scale 205 -> inv 319, out 51x51
    cmd_ready = 1'b1;
    res_auto  = 1'b1;
    start_frame(64, 64, 205, 51, 51, 319);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_clear", 64'({done, err}), 64'd0);
    edges = 1;
    while (!cmd_valid && edges < 40) begin
      tick(1);
      edges++;
    end
    check("t1_first_valid_cycle", 64'(edges), 64'd18);
    wait_done("t1_done", 20000);
    check("t1_count", 64'(n_xfer), 64'd2601);
    check("t1_last_n", 64'(n_last), 64'd1);
    check("t1_last_pos", 64'({last_ox, last_oy}), 64'({16'd50, 16'd50}));
    check("t1_err", 64'({err, busy}), 64'd0);
    check("t1_ox1", 64'(row0[1]), 64'({16'd1, 8'd63}));
    check("t1_ox50", 64'(row0[50]), 64'({16'd62, 8'd78}));
`ifdef BSEQ_PERF_EN
    check("t1_perf", 64'(perf_cycles), 64'(n_busy));
`else
    check("t1_perf", 64'(perf_cycles), 64'd0);
`endif
    tick(4);

    // 2: 4x4 upscale x2 -> inv 128, out 8x8, right edge clamps
    start_frame(4, 4, 512, 8, 8, 128);
    wait_done("t2_done", 2000);
    check("t2_count", 64'(n_xfer), 64'd64);
    check("t2_last_pos", 64'({last_ox, last_oy}), 64'({16'd7, 16'd7}));
    check("t2_ox5", 64'(row0[5]), 64'({16'd2, 8'd128}));
    check("t2_ox6", 64'(row0[6]), 64'({16'd3, 8'd0}));
    check("t2_ox7", 64'(row0[7]), 64'({16'd3, 8'd0}));
    check("t2_err", 64'(err), 64'd0);
    tick(4);

    // 3: rejected configs
    start_frame(64, 64, 1, 1, 1, 0);
    tick(1);
    check("t3_scale1_flags", 64'({err, done}), 64'd3);
    tick(20);
    check("t3_scale1_novalid", 64'(n_valid), 64'd0);
    start_frame(0, 64, 205, 1, 1, 0);
    tick(1);
    check("t3_w0_flags", 64'({err, done}), 64'd3);
    tick(20);
    check("t3_w0_novalid", 64'(n_valid), 64'd0);
    start_frame(1024, 4, 512, 1, 1, 0);
    tick(22);
    check("t3_big_flags", 64'({err, done, busy}), 64'd6);
    check("t3_big_novalid", 64'(n_valid), 64'd0);
`ifdef BSEQ_PERF_EN
    check("t3_big_perf", 64'(perf_cycles), 64'd17);
`endif

    // 4: back-pressure holds the command stable, one transfer per ready cycle
    cmd_ready = 1'b0;
    start_frame(4, 4, 512, 8, 8, 128);
    check("t4_clear", 64'({err, done}), 64'd0);
    edges = 1;
    while (!cmd_valid && edges < 40) begin
      tick(1);
      edges++;
    end
    snap_pos = {cmd_ox, cmd_oy};
    snap_pt  = {cmd_x0, cmd_fx, cmd_y0, cmd_fy};
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t4_hold_valid", 64'(cmd_valid), 64'd1);
      check("t4_hold_cmd", 64'({snap_pos, cmd_ox, cmd_oy}), 64'({snap_pos, snap_pos}));
      check("t4_hold_pt", 64'({cmd_x0, cmd_fx, cmd_y0, cmd_fy}), 64'(snap_pt));
    end
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    tick(3);
    check("t4_one_xfer", 64'(n_xfer), 64'd1);
    check("t4_next_pos", 64'({cmd_valid, cmd_ox, cmd_oy}), 64'({1'b1, 16'd1, 16'd0}));
    cmd_ready = 1'b1;
    wait_done("t4_done", 2000);
    check("t4_count", 64'(n_xfer), 64'd64);
    tick(4);

    // 5: results withheld -> in-flight limit
    res_auto = 1'b0;
    res_man  = 1'b0;
    start_frame(4, 4, 512, 8, 8, 128);
    tick(40);
    check("t5_limit", 64'(n_xfer), 64'd4);
    check("t5_stalled", 64'(cmd_valid), 64'd0);
    res_man = 1'b1;
    tick(1);
    res_man = 1'b0;
    tick(10);
    check("t5_one_more", 64'(n_xfer), 64'd5);
    check("t5_stalled2", 64'(cmd_valid), 64'd0);

    // 6: reset mid-run, then a clean restart
    rst_sys_n = 1'b0;
    #1;
    check("t6_rst_stall", 64'({cmd_valid, busy, done, err}), 64'd0);
    tick(2);
    rst_sys_n = 1'b1;
    res_auto  = 1'b1;
    tick(2);
    start_frame(4, 4, 512, 8, 8, 128);
    edges = 0;
    while (n_xfer < 10 && edges < 200) begin
      tick(1);
      edges++;
    end
    check("t6_running", 64'({busy, cmd_valid}), 64'd3);
    rst_sys_n = 1'b0;
    #1;
    check("t6_rst_status", 64'({cmd_valid, busy, done, err, cmd_last}), 64'd0);
    check("t6_rst_cmd", 64'({cmd_ox, cmd_oy, cmd_x0}), 64'd0);
    check("t6_rst_perf", 64'(perf_cycles), 64'd0);
    tick(3);
    rst_sys_n = 1'b1;
    tick(3);
    start_frame(4, 4, 512, 8, 8, 128);
    wait_done("t6_done", 2000);
    check("t6_count", 64'(n_xfer), 64'd64);
    check("t6_last_pos", 64'({last_ox, last_oy}), 64'({16'd7, 16'd7}));
`ifdef BSEQ_PERF_EN
    check("t6_perf", 64'(perf_cycles), 64'(n_busy));
`else
    check("t6_perf", 64'(perf_cycles), 64'd0);
`endif
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
